spart_rx: RTL and testbench

SPART receive stage, directly upstream of the SPART bus interface. Oversamples the asynchronous RxD line using the baud generator's enable tick and deframes 8N1 characters, LSB first. Presents the received byte on rx_data (the bus interface's rx2bus) and a receive-data-available flag rda. Clears rda when the processor reads the IO_XFER address; raises and clears framing and overrun flags.

---
 rtl/spart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_spart_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// spart_rx: SPART receive stage.
// Oversamples the asynchronous rxd line on the baud generator's enable tick and
// deframes 8N1 characters, LSB first. The received byte and the data-available
// flag feed the bus interface; processor reads clear the flags.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, active low
//   enable      single-cycle oversample tick from the baud generator
//   rxd         asynchronous serial receive line, idle high
//   iocs        chip select
//   iorw        1 = processor read
//   ioaddr      00 IO_XFER, 01 REG_RD (status), 1x divisor
//   rx_data     last correctly framed byte
//   rda         receive data available
//   framing_err sticky, stop bit sampled low
//   overrun     sticky, byte completed while rda was already set
//
// State   | meaning
// S_IDLE  | line idle, waiting for a low sample
// S_START | start bit seen, confirming it at mid-bit
// S_DATA  | shifting in 8 data bits, sampled mid-bit
// S_STOP  | checking the stop bit
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int SAMPLE_PT  = OVERSAMPLE / 2 - 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rxd,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_SAMPLE = TW'(SAMPLE_PT);
  localparam logic [TW-1:0] TICK_LAST   = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            rxs_q, rxs_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rda_q, rda_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  logic            xfer_rd;
  logic            stat_rd;
  logic            done_ok;
  logic            done_bad;

  always_comb begin
    state_d   = state_q;
    sync1_d   = rxd;
    rxs_d     = sync1_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    done_ok   = 1'b0;
    done_bad  = 1'b0;

    xfer_rd = iocs & iorw & (ioaddr == 2'b00);
    stat_rd = iocs & iorw & (ioaddr == 2'b01);

    if (enable) begin
      case (state_q)
        S_IDLE: begin
          tick_d = '0;
          // The detecting tick counts as tick 0, so START begins at 1.
          if (!rxs_q) begin
            state_d = S_START;
            tick_d  = TW'(1);
          end
        end
        S_START: begin
          if (tick_q == TICK_SAMPLE) begin
            // Restarting the count here puts every later sample mid-bit.
            tick_d = '0;
            if (rxs_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              bit_d   = 3'd0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d         = '0;
            shift_d[bit_q] = rxs_q;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            // Finishing at mid stop bit leaves half a bit of margin for
            // baud mismatch before the next start edge.
            tick_d  = '0;
            bit_d   = 3'd0;
            state_d = S_IDLE;
            if (rxs_q) begin
              done_ok = 1'b1;
            end else begin
              done_bad = 1'b1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
          bit_d   = 3'd0;
        end
      endcase
    end

    rx_data_d = done_ok ? shift_q : rx_data_q;

    // A completion outranks a same-cycle IO_XFER read.
    if (done_ok) begin
      rda_d = 1'b1;
    end else if (xfer_rd) begin
      rda_d = 1'b0;
    end else begin
      rda_d = rda_q;
    end

    // Data consumed in the completion cycle is not an overrun.
    if (done_ok && rda_q && !xfer_rd) begin
      ovr_d = 1'b1;
    end else if (stat_rd) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    if (done_bad) begin
      ferr_d = 1'b1;
    end else if (stat_rd) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      tick_q    <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rda_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rxs_q     <= rxs_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: directed bench for spart_rx with OVERSAMPLE=16 and an enable
// tick every 4th clk. All stimulus changes on the falling edge; outputs are
// checked on the falling edge after the rising edge of interest.
module tb_spart_rx;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       rxd;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  logic [1:0] ph;
  int         n_chk;
  int         n_bad;

  spart_rx #(.OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rxd         (rxd),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; enable is high for one clk in every four.
  task automatic cyc();
    @(negedge clk);
    ph     = ph + 2'd1;
    enable = (ph == 2'd0);
  endtask

  task automatic io_access(input logic rw, input logic [1:0] addr);
    iocs   = 1'b1;
    iorw   = rw;
    ioaddr = addr;
    cyc();
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = 2'b00;
  endtask

  // Start edge lands just before an enable tick, so the stop-bit sample
  // happens on the 609th rising edge after the start edge (tick 152).
  // rd_done pulses an IO_XFER read in exactly that cycle.
  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit rd_done);
    while (ph != 2'd3) cyc();
    cyc();
    rxd = 1'b0;
    repeat (64) cyc();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (64) cyc();
    end
    rxd = bad_stop ? 1'b0 : 1'b1;
    repeat (32) cyc();
    if (rd_done) begin
      iocs   = 1'b1;
      iorw   = 1'b1;
      ioaddr = 2'b00;
    end
    cyc();
    iocs = 1'b0;
    iorw = 1'b0;
    if (bad_stop) begin
      // Short low stop: the restart it triggers is rejected as a false start.
      repeat (7) cyc();
      rxd = 1'b1;
      repeat (60) cyc();
    end else begin
      repeat (31) cyc();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    ph     = 2'd0;
    rst_n  = 1'b0;
    enable = 1'b0;
    rxd    = 1'b1;
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = 2'b00;

    repeat (3) cyc();
    chk("rst_data", rx_data, 8'h00);
    chk("rst_rda", {7'd0, rda}, 8'h00);
    chk("rst_ferr", {7'd0, framing_err}, 8'h00);
    chk("rst_ovr", {7'd0, overrun}, 8'h00);
    rst_n = 1'b1;
    repeat (20) cyc();

    send_frame(8'hA5, 1'b0, 1'b0);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_rda", {7'd0, rda}, 8'h01);
    chk("a5_ferr", {7'd0, framing_err}, 8'h00);
    chk("a5_ovr", {7'd0, overrun}, 8'h00);

    io_access(1'b0, 2'b00);
    chk("wr_xfer_rda", {7'd0, rda}, 8'h01);
    io_access(1'b1, 2'b10);
    chk("rd_div_rda", {7'd0, rda}, 8'h01);
    io_access(1'b1, 2'b00);
    chk("xfer_rda", {7'd0, rda}, 8'h00);
    chk("xfer_data", rx_data, 8'hA5);

    send_frame(8'h3C, 1'b0, 1'b0);
    chk("3c_data", rx_data, 8'h3C);
    chk("3c_ovr", {7'd0, overrun}, 8'h00);
    send_frame(8'h81, 1'b0, 1'b0);
    chk("81_data", rx_data, 8'h81);
    chk("81_rda", {7'd0, rda}, 8'h01);
    chk("81_ovr", {7'd0, overrun}, 8'h01);
    io_access(1'b0, 2'b01);
    chk("wr_stat_ovr", {7'd0, overrun}, 8'h01);
    io_access(1'b1, 2'b01);
    chk("stat_ovr", {7'd0, overrun}, 8'h00);
    chk("stat_rda", {7'd0, rda}, 8'h01);

    send_frame(8'h55, 1'b1, 1'b0);
    chk("55_ferr", {7'd0, framing_err}, 8'h01);
    chk("55_rda", {7'd0, rda}, 8'h01);
    chk("55_data", rx_data, 8'h81);
    chk("55_ovr", {7'd0, overrun}, 8'h00);

    send_frame(8'h12, 1'b0, 1'b0);
    chk("12_data", rx_data, 8'h12);
    chk("12_rda", {7'd0, rda}, 8'h01);
    chk("12_ovr", {7'd0, overrun}, 8'h01);
    chk("12_ferr", {7'd0, framing_err}, 8'h01);
    io_access(1'b1, 2'b01);
    chk("clr_ferr", {7'd0, framing_err}, 8'h00);
    chk("clr_ovr", {7'd0, overrun}, 8'h00);

    while (ph != 2'd3) cyc();
    cyc();
    rxd = 1'b0;
    repeat (20) cyc();
    rxd = 1'b1;
    repeat (100) cyc();
    chk("glitch_data", rx_data, 8'h12);
    chk("glitch_rda", {7'd0, rda}, 8'h01);
    chk("glitch_ferr", {7'd0, framing_err}, 8'h00);
    chk("glitch_ovr", {7'd0, overrun}, 8'h00);
    io_access(1'b1, 2'b00);
    chk("glitch_clr", {7'd0, rda}, 8'h00);

    send_frame(8'hFF, 1'b0, 1'b0);
    chk("ff_data", rx_data, 8'hFF);
    chk("ff_rda", {7'd0, rda}, 8'h01);
    chk("ff_ovr", {7'd0, overrun}, 8'h00);

    // Abort a 0x0F frame in the middle of bit 3.
    while (ph != 2'd3) cyc();
    cyc();
    rxd = 1'b0;
    repeat (64) cyc();
    for (int i = 0; i < 3; i++) begin
      rxd = 1'b1;
      repeat (64) cyc();
    end
    repeat (32) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_rda", {7'd0, rda}, 8'h00);
    repeat (300) cyc();
    chk("post_rst_rda", {7'd0, rda}, 8'h00);
    chk("post_rst_data", rx_data, 8'h00);

    send_frame(8'h0F, 1'b0, 1'b0);
    chk("0f_data", rx_data, 8'h0F);
    chk("0f_rda", {7'd0, rda}, 8'h01);
    chk("0f_ferr", {7'd0, framing_err}, 8'h00);

    send_frame(8'h6B, 1'b0, 1'b1);
    chk("race_data", rx_data, 8'h6B);
    chk("race_rda", {7'd0, rda}, 8'h01);
    chk("race_ovr", {7'd0, overrun}, 8'h00);
    io_access(1'b1, 2'b00);
    chk("race_clr", {7'd0, rda}, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
